// File: rtl/usb_fs_tx_if.sv
// Byte-stream handshake between the protocol engine (master) and usb_fs_tx (slave).
interface usb_fs_tx_if;
    localparam int unsigned DATA_W = 8;

    logic              pkt_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;
    logic              busy;
    logic              underrun;

    modport master (
        output pkt_start, tx_data, tx_valid, tx_last,
        input  tx_ready, busy, underrun
    );

    modport slave (
        input  pkt_start, tx_data, tx_valid, tx_last,
        output tx_ready, busy, underrun
    );
endinterface

// File: rtl/usb_fs_tx.sv
// Full-speed USB serial transmitter: SYNC, NRZI-encoded bit-stuffed payload, EOP.
// One line bit every 4 clocks of the 48 MHz domain.
module usb_fs_tx (
    input  logic       clk_48mhz,
    input  logic       reset,
    usb_fs_tx_if.slave tx,
    output logic       usb_p_tx,
    output logic       usb_n_tx,
    output logic       usb_tx_en
);
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned PHASE_W     = 2;
    localparam int unsigned BIT_CNT_W   = 3;
    localparam int unsigned STUFF_CNT_W = 3;
    localparam int unsigned STUFF_LIMIT = 6;
    localparam logic [BYTE_W-1:0] SYNC_PATTERN = 8'h80;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t                 state;
    logic [PHASE_W-1:0]     phase;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [STUFF_CNT_W-1:0] stuff_cnt;
    logic [BYTE_W-1:0]      shreg;
    logic                   last_q;
    logic                   line_j;

    logic strobe_c;
    logic stuff_c;
    logic fetch_c;
    logic shift_c;
    logic launch_c;
    logic launch_bit_c;

    // Decide what the next bit slot carries: a stuff bit, a byte fetch, or the next shifted bit.
    always_comb begin
        strobe_c = (phase == {PHASE_W{1'b1}});
        stuff_c  = 1'b0;
        fetch_c  = 1'b0;
        shift_c  = 1'b0;
        if (strobe_c && (state == SYNC || state == DATA)) begin
            if (stuff_cnt == STUFF_CNT_W'(STUFF_LIMIT)) begin
                stuff_c = 1'b1;
            end else if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                fetch_c = !last_q;
            end else begin
                shift_c = 1'b1;
            end
        end
        launch_bit_c = fetch_c ? tx.tx_data[0] : shreg[0];
        launch_c     = shift_c || (fetch_c && tx.tx_valid);
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            stuff_cnt   <= '0;
            shreg       <= '0;
            last_q      <= 1'b0;
            line_j      <= 1'b1;
            usb_p_tx    <= 1'b1;
            usb_n_tx    <= 1'b0;
            usb_tx_en   <= 1'b0;
            tx.tx_ready <= 1'b0;
            tx.busy     <= 1'b0;
            tx.underrun <= 1'b0;
        end else begin
            tx.tx_ready <= 1'b0;
            tx.underrun <= 1'b0;
            if (state != IDLE) begin
                phase <= phase + PHASE_W'(1);
            end
            case (state)
                IDLE: begin
                    // The first SYNC bit (a 0, so J->K) goes out on the accepting edge.
                    if (tx.pkt_start) begin
                        state     <= SYNC;
                        phase     <= '0;
                        bit_cnt   <= '0;
                        stuff_cnt <= '0;
                        last_q    <= 1'b0;
                        shreg     <= SYNC_PATTERN >> 1;
                        line_j    <= 1'b0;
                        usb_p_tx  <= 1'b0;
                        usb_n_tx  <= 1'b1;
                        usb_tx_en <= 1'b1;
                        tx.busy   <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (stuff_c) begin
                        stuff_cnt <= '0;
                        line_j    <= ~line_j;
                        usb_p_tx  <= ~line_j;
                        usb_n_tx  <= line_j;
                    end else if (launch_c) begin
                        // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones.
                        if (launch_bit_c) begin
                            stuff_cnt <= stuff_cnt + STUFF_CNT_W'(1);
                        end else begin
                            stuff_cnt <= '0;
                            line_j    <= ~line_j;
                            usb_p_tx  <= ~line_j;
                            usb_n_tx  <= line_j;
                        end
                        if (fetch_c) begin
                            state       <= DATA;
                            tx.tx_ready <= 1'b1;
                            last_q      <= tx.tx_last;
                            shreg       <= tx.tx_data >> 1;
                            bit_cnt     <= '0;
                        end else begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end else if (strobe_c) begin
                        // End of the last byte, or a byte was needed and none was offered.
                        tx.underrun <= fetch_c;
                        state       <= EOP_SE0;
                        bit_cnt     <= '0;
                        usb_p_tx    <= 1'b0;
                        usb_n_tx    <= 1'b0;
                    end
                end
                EOP_SE0: begin
                    if (strobe_c) begin
                        if (bit_cnt == '0) begin
                            bit_cnt <= BIT_CNT_W'(1);
                        end else begin
                            state    <= EOP_J;
                            usb_p_tx <= 1'b1;
                            usb_n_tx <= 1'b0;
                        end
                    end
                end
                EOP_J: begin
                    if (strobe_c) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        stuff_cnt <= '0;
                        line_j    <= 1'b1;
                        usb_tx_en <= 1'b0;
                        tx.busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
